q_update_ctrl: RTL and testbench
================================

Name: q_update_ctrl

Overview:
- Sequencer for the Q-learning update datapath: per-action Q RAMs, action mux, max-Q block and Q updater.
- Accepts one transition (state, action, next_state, reward) over a valid/ready handshake.
- Steps the datapath through three phases: read old Q(s,a), read the next-state row for max Q, then write the updated Q back to exactly one action RAM.
- Also provides a table-clear sweep that zeroes every entry. Sits between the agent/host interface and the accelerator datapath.

Parameters:
- N_STATE, 16: number of states (rows per action RAM).
- N_ACT, 15: number of action RAMs.
- S_W, 4: state address width, clog2(N_STATE).
- A_W, 4: action index width.
- RD_LAT, 1: RAM read latency in cycles.
- MAX_LAT, 1: max-Q block register latency.
- UPD_LAT, 1: cycles from max_q_ld until the updater result is stable.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tr_valid  in  1  transition offered.
- tr_ready  out  1  controller can accept a transition.
- tr_state  in  S_W  current state s.
- tr_action  in  A_W  action a.
- tr_next_state  in  S_W  next state s'.
- tr_reward  in  16  reward, forwarded to the datapath.
- clr_req  in  1  level request to zero the Q table.
- rd_addr  out  S_W  read address to all action RAMs.
- wr_addr  out  S_W  write address to all action RAMs.
- act_sel  out  A_W  action mux select, registered copy of tr_action.
- reward_q  out  16  registered reward held for the updater.
- wr_en  out  N_ACT  per-RAM write enables.
- wr_zero  out  1  forces RAM write data to 0 (clear sweep).
- old_q_ld  out  1  one-cycle strobe: capture selected old Q.
- max_q_ld  out  1  one-cycle strobe: capture max Q.
- busy  out  1  FSM not in IDLE.
- upd_done  out  1  one-cycle pulse on completed update.
- act_err  out  1  one-cycle pulse: transition dropped for illegal action.
- upd_count  out  32  number of completed updates.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. tr_ready=0 during reset, 1 the cycle after release. All other outputs are 0, and wr_en is forced to 0 immediately. The wait counter and upd_count clear. Reset mid-update or mid-clear aborts with no further writes.
- States: IDLE, RD_OLD, RD_NEXT, CALC, WRITE, CLEAR. A single down-counter `wait_cnt` times each state.
- IDLE: tr_ready=1.
  - If clr_req=1: go to CLEAR, wr_addr=0. Clear wins over a simultaneous tr_valid, and tr_ready is forced 0 that cycle.
  - Else if tr_valid=1 (accept): register s, a, s', reward.
    - a >= N_ACT: pulse act_err next cycle, stay IDLE, no RAM access, count unchanged.
    - Otherwise go to RD_OLD.
- RD_OLD: rd_addr=s for RD_LAT cycles. old_q_ld=1 in the last of them, then go to RD_NEXT.
- RD_NEXT: rd_addr=s' for RD_LAT+MAX_LAT cycles. max_q_ld=1 in the last, then go to CALC.
- CALC: hold for UPD_LAT cycles (minimum 1), then go to WRITE.
- WRITE: exactly one cycle. wr_addr=s, wr_en = one-hot(a), wr_zero=0. Then go to IDLE with upd_done=1 and upd_count+1 (wraps at 2^32).
- s == s' is legal; RD_OLD completes before RD_NEXT, so there is no hazard. The write in WRITE is visible to the next transition's reads.
- CLEAR: wr_en = all ones, wr_zero=1, wr_addr increments each cycle from 0 to N_STATE-1 (N_STATE cycles). Then go to IDLE. upd_count is not changed.
- clr_req asserted while busy is held off until the next IDLE. A clr_req still high on return to IDLE starts another sweep.
- tr_ready=0 in every non-IDLE state, and input changes there are ignored.
- Default latency: acceptance at T, write at T+5, upd_done and tr_ready at T+6. Throughput is 1 transition per 6 cycles.
- rd_addr holds its last value when not reading. wr_en=0 outside WRITE/CLEAR.

Decomposition:
- Shared package `qlearn_pkg`:
  - FSM state enum.
  - Default widths S_W, A_W and data width 16.
  - Latency constants RD_LAT, MAX_LAT, UPD_LAT.
- One sub-module `act_onehot_dec`: A_W-bit action to N_ACT one-hot, gated by enable, all-zero for out-of-range index. Also reused by the datapath.

Test Plan:
- Reset release, tr_valid=1 (s=3, a=5, s'=7), defaults:
  - rd_addr=3 at T+1, old_q_ld at T+1.
  - rd_addr=7 at T+2..T+3, max_q_ld at T+3.
  - wr_en=0x0020, wr_addr=3 at T+5.
  - upd_done at T+6, upd_count=1.
- clr_req pulse in IDLE, N_STATE=16: wr_en=0x7FFF and wr_zero=1 for 16 cycles with wr_addr 0..15, tr_ready=0 throughout, then IDLE.
- tr_valid with a=15 (>=N_ACT): act_err pulse, no wr_en activity, upd_count unchanged, tr_ready stays 1.
- clr_req and tr_valid in the same IDLE cycle: CLEAR runs and the transition is not accepted. Transition is accepted after the sweep if tr_valid is still high.
- rst_n low during RD_NEXT: wr_en, busy and strobes go 0 immediately, no write occurs, upd_count=0.
- 1000 back-to-back transitions with tr_valid held high: exactly one write per transition, 6-cycle spacing, upd_count=1000. Include s=s'=0 and a=14 corner cases.

Source files
------------

// File: rtl/qlearn_pkg.sv
// qlearn_pkg: shared widths, latencies and FSM state encoding for the Q-learning update path
package qlearn_pkg;
  localparam int DEF_S_W = 4;
  localparam int DEF_A_W = 4;
  localparam int D_W = 16;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_MAX_LAT = 1;
  localparam int DEF_UPD_LAT = 1;
  typedef enum logic [2:0] {ST_IDLE, ST_RD_OLD, ST_RD_NEXT, ST_CALC, ST_WRITE, ST_CLEAR} q_state_t;
endpackage

// File: rtl/act_onehot_dec.sv
// act_onehot_dec: gated action index to one-hot RAM select, all-zero when out of range
module act_onehot_dec #(
  parameter int A_W = 4,
  parameter int N_ACT = 15
) (
  input  logic             en,
  input  logic [A_W-1:0]   idx,
  output logic [N_ACT-1:0] onehot
);
  for (genvar i = 0; i < N_ACT; i++) begin : g_dec
    assign onehot[i] = en && (32'(idx) == i);
  end
endmodule

// File: rtl/q_update_ctrl.sv
// q_update_ctrl: sequences read-old, read-next, calc and write-back phases plus table-clear sweep
module q_update_ctrl
  import qlearn_pkg::*;
#(
  parameter int N_STATE = 16,
  parameter int N_ACT = 15,
  parameter int S_W = DEF_S_W,
  parameter int A_W = DEF_A_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int MAX_LAT = DEF_MAX_LAT,
  parameter int UPD_LAT = DEF_UPD_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tr_valid,
  output logic             tr_ready,
  input  logic [S_W-1:0]   tr_state,
  input  logic [A_W-1:0]   tr_action,
  input  logic [S_W-1:0]   tr_next_state,
  input  logic [D_W-1:0]   tr_reward,
  input  logic             clr_req,
  output logic [S_W-1:0]   rd_addr,
  output logic [S_W-1:0]   wr_addr,
  output logic [A_W-1:0]   act_sel,
  output logic [D_W-1:0]   reward_q,
  output logic [N_ACT-1:0] wr_en,
  output logic             wr_zero,
  output logic             old_q_ld,
  output logic             max_q_ld,
  output logic             busy,
  output logic             upd_done,
  output logic             act_err,
  output logic [31:0]      upd_count
);
  localparam int CALC_CYC = UPD_LAT < 1 ? 1 : UPD_LAT;
  localparam int CW = $clog2(N_STATE + RD_LAT + MAX_LAT + CALC_CYC);
  q_state_t state, nxt;
  logic [CW-1:0] wait_cnt, nxt_cnt;
  logic [S_W-1:0] s_q, ns_q, rd_last;
  logic [N_ACT-1:0] dec_oh;
  logic rdy_en, acc, legal, done;
  assign done = wait_cnt == '0;
  assign legal = 32'(tr_action) < N_ACT;
  assign tr_ready = rdy_en && state == ST_IDLE && !clr_req;
  assign busy = state != ST_IDLE;
  assign rd_addr = state == ST_RD_OLD ? s_q : state == ST_RD_NEXT ? ns_q : rd_last;
  assign wr_zero = state == ST_CLEAR;
  assign wr_addr = wr_zero ? S_W'(CW'(N_STATE - 1) - wait_cnt) : s_q;
  assign wr_en = wr_zero ? '1 : dec_oh;
  assign old_q_ld = state == ST_RD_OLD && done;
  assign max_q_ld = state == ST_RD_NEXT && done;
  act_onehot_dec #(.A_W(A_W), .N_ACT(N_ACT)) u_dec (
    .en(state == ST_WRITE),
    .idx(act_sel),
    .onehot(dec_oh)
  );
  // next state and phase timer; clear wins over a simultaneous transition
  always_comb begin
    nxt = state;
    nxt_cnt = done ? '0 : wait_cnt - 1'b1;
    acc = 1'b0;
    case (state)
      ST_IDLE:
        if (rdy_en && clr_req) begin
          nxt = ST_CLEAR;
          nxt_cnt = CW'(N_STATE - 1);
        end else if (rdy_en && tr_valid) begin
          acc = 1'b1;
          nxt = legal ? ST_RD_OLD : ST_IDLE;
          nxt_cnt = legal ? CW'(RD_LAT - 1) : '0;
        end
      ST_RD_OLD:
        if (done) begin
          nxt = ST_RD_NEXT;
          nxt_cnt = CW'(RD_LAT + MAX_LAT - 1);
        end
      ST_RD_NEXT:
        if (done) begin
          nxt = ST_CALC;
          nxt_cnt = CW'(CALC_CYC - 1);
        end
      ST_CALC: nxt = done ? ST_WRITE : ST_CALC;
      ST_WRITE: nxt = ST_IDLE;
      ST_CLEAR: nxt = done ? ST_IDLE : ST_CLEAR;
      default: nxt = ST_IDLE;
    endcase
  end
  // FSM state, phase timer and ready-after-reset flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wait_cnt <= '0;
      rdy_en <= 1'b0;
    end else begin
      state <= nxt;
      wait_cnt <= nxt_cnt;
      rdy_en <= 1'b1;
    end
  end
  // transition capture, status pulses and update counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      ns_q <= '0;
      act_sel <= '0;
      reward_q <= '0;
      rd_last <= '0;
      act_err <= 1'b0;
      upd_done <= 1'b0;
      upd_count <= '0;
    end else begin
      if (acc) begin
        s_q <= tr_state;
        ns_q <= tr_next_state;
        act_sel <= tr_action;
        reward_q <= tr_reward;
      end
      rd_last <= rd_addr;
      act_err <= acc && !legal;
      upd_done <= state == ST_WRITE;
      upd_count <= upd_count + 32'(state == ST_WRITE);
    end
  end
endmodule

// File: tb/tb_q_update_ctrl.sv
// tb_q_update_ctrl: vector table, scoreboarded write checks and multi-cycle corner sequences
module tb_q_update_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tr_valid = 1'b0;
  logic tr_ready;
  logic [3:0] tr_state = '0;
  logic [3:0] tr_action = '0;
  logic [3:0] tr_next_state = '0;
  logic [15:0] tr_reward = '0;
  logic clr_req = 1'b0;
  logic [3:0] rd_addr, wr_addr, act_sel;
  logic [15:0] reward_q;
  logic [14:0] wr_en;
  logic wr_zero, old_q_ld, max_q_ld, busy, upd_done, act_err;
  logic [31:0] upd_count;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [31:0] sb[$];
  typedef struct {
    logic [3:0] s;
    logic [3:0] a;
    logic [3:0] ns;
    logic [15:0] r;
    logic [14:0] en;
    logic err;
  } vec_t;
  vec_t vt[6];

  q_update_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_state(tr_state), .tr_action(tr_action), .tr_next_state(tr_next_state),
    .tr_reward(tr_reward), .clr_req(clr_req), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .act_sel(act_sel), .reward_q(reward_q), .wr_en(wr_en), .wr_zero(wr_zero),
    .old_q_ld(old_q_ld), .max_q_ld(max_q_ld), .busy(busy), .upd_done(upd_done),
    .act_err(act_err), .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", n, act, exp);
    end
  endfunction

  // every normal write is matched against the oldest expected {addr, one-hot}
  always @(negedge clk) begin
    if (rst_n && wr_en != '0 && !wr_zero) begin
      if (sb.size() == 0) chk("unexpected_write", 32'({wr_addr, wr_en}), 32'hFFFF_FFFF);
      else chk("sb_write", 32'({wr_addr, wr_en}), sb.pop_front());
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tr_ready && n < 50) begin
      step();
      n++;
    end
    if (!tr_ready) chk("ready_timeout", 32'(tr_ready), 32'd1);
  endtask

  task automatic drive(logic [3:0] s, logic [3:0] a, logic [3:0] ns, logic [15:0] r);
    tr_valid = 1'b1;
    tr_state = s;
    tr_action = a;
    tr_next_state = ns;
    tr_reward = r;
  endtask

  task automatic apply_vec(vec_t v);
    wait_ready();
    drive(v.s, v.a, v.ns, v.r);
    if (!v.err) sb.push_back(32'({v.s, v.en}));
    @(posedge clk);
    #1;
    tr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (v.err) begin
        if (k == 1) begin
          chk("err_pulse", 32'(act_err), 32'd1);
          chk("err_ready", 32'(tr_ready), 32'd1);
          chk("err_busy", 32'(busy), 32'd0);
        end else if (k == 2) begin
          chk("err_pulse_end", 32'(act_err), 32'd0);
          chk("err_count", upd_count, 32'(exp_cnt));
        end
      end else begin
        if (k == 1) begin
          chk("rd_old_addr", 32'(rd_addr), 32'(v.s));
          chk("old_q_ld", 32'(old_q_ld), 32'd1);
          chk("act_sel", 32'(act_sel), 32'(v.a));
          chk("reward_q", 32'(reward_q), 32'(v.r));
          chk("busy_ready", 32'({busy, tr_ready}), 32'b10);
        end
        if (k == 2) chk("rd_next_a", 32'({rd_addr, max_q_ld}), 32'({v.ns, 1'b0}));
        if (k == 3) chk("rd_next_b", 32'({rd_addr, max_q_ld}), 32'({v.ns, 1'b1}));
        if (k == 4) chk("calc_no_wr", 32'(wr_en), 32'd0);
        if (k == 5) chk("write", 32'({wr_addr, wr_en, wr_zero}), 32'({v.s, v.en, 1'b0}));
        if (k == 6) begin
          exp_cnt++;
          chk("done_ready", 32'({upd_done, tr_ready}), 32'b11);
          chk("upd_count", upd_count, 32'(exp_cnt));
        end
      end
    end
  endtask

  task automatic check_sweep();
    for (int i = 0; i < 16; i++) begin
      step();
      chk("clr_wr", 32'({wr_en, wr_zero, tr_ready}), 32'({15'h7FFF, 1'b1, 1'b0}));
      chk("clr_addr", 32'(wr_addr), 32'(i));
    end
  endtask

  initial begin
    vt[0] = '{s: 4'd3, a: 4'd5, ns: 4'd7, r: 16'h0100, en: 15'h0020, err: 1'b0};
    vt[1] = '{s: 4'd0, a: 4'd0, ns: 4'd0, r: 16'hFFFF, en: 15'h0001, err: 1'b0};
    vt[2] = '{s: 4'd15, a: 4'd14, ns: 4'd9, r: 16'h1234, en: 15'h4000, err: 1'b0};
    vt[3] = '{s: 4'd6, a: 4'd15, ns: 4'd2, r: 16'h0055, en: 15'h0000, err: 1'b1};
    vt[4] = '{s: 4'd9, a: 4'd2, ns: 4'd9, r: 16'h8000, en: 15'h0004, err: 1'b0};
    vt[5] = '{s: 4'd12, a: 4'd7, ns: 4'd1, r: 16'h0042, en: 15'h0080, err: 1'b0};
    step();
    chk("rst_ready", 32'(tr_ready), 32'd0);
    chk("rst_outs", 32'({busy, wr_en, wr_zero, old_q_ld, max_q_ld, upd_done, act_err}), 32'd0);
    chk("rst_count", upd_count, 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(tr_ready), 32'd1);
    for (int i = 0; i < 6; i++) apply_vec(vt[i]);
    // clear sweep from a single-cycle request
    wait_ready();
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    check_sweep();
    step();
    chk("clr_exit", 32'({wr_en, busy, tr_ready}), 32'b1);
    chk("clr_count", upd_count, 32'(exp_cnt));
    // clear and transition in the same cycle: sweep first, transition after
    drive(4'd2, 4'd1, 4'd4, 16'h0007);
    clr_req = 1'b1;
    #1;
    chk("clr_vs_valid_ready", 32'(tr_ready), 32'd0);
    sb.push_back(32'({4'd2, 15'h0002}));
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    check_sweep();
    step();
    chk("post_clr_accept", 32'({busy, tr_ready}), 32'b01);
    @(posedge clk);
    #1;
    tr_valid = 1'b0;
    begin
      int n = 0;
      while (!upd_done && n < 20) begin
        step();
        n++;
      end
      exp_cnt++;
      chk("post_clr_done", 32'(upd_done), 32'd1);
      chk("post_clr_count", upd_count, 32'(exp_cnt));
    end
    // reset while in RD_NEXT aborts the write
    wait_ready();
    drive(4'd5, 4'd3, 4'd8, 16'h0001);
    sb.push_back(32'({4'd5, 15'h0008}));
    @(posedge clk);
    #1;
    tr_valid = 1'b0;
    step();
    step();
    chk("pre_rst_rd_next", 32'({busy, rd_addr}), 32'({1'b1, 4'd8}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 32'({wr_en, busy, old_q_ld, max_q_ld, tr_ready}), 32'd0);
    chk("abort_count", upd_count, 32'd0);
    sb.delete();
    exp_cnt = 0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("abort_idle", 32'({busy, tr_ready, upd_count[0]}), 32'b010);
    // back-to-back transitions with tr_valid held high
    wait_ready();
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] s, a, ns;
      int n;
      s = (i == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ns = (i == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      a = (i == 1) ? 4'd14 : 4'($urandom_range(0, 14));
      drive(s, a, ns, 16'($urandom));
      sb.push_back(32'({s, 15'(1 << a)}));
      @(posedge clk);
      #1;
      n = 0;
      do begin
        step();
        n++;
      end while (!tr_ready && n < 20);
      chk("b2b_spacing", 32'(n), 32'd6);
    end
    tr_valid = 1'b0;
    exp_cnt += 1000;
    step();
    chk("b2b_count", upd_count, 32'(exp_cnt));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
